// File: rtl/instr_fetch_queue.sv
// Prefetch queue between instruction memory and the IF/ID register: owns the fetch PC,
// buffers {pc+4, instr} pairs in a circular FIFO and presents the head to decode.
module instr_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0041_0020
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [31:0]              flush_pc,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Storage is data-only; validity is tracked by count_q, so no reset needed.
  logic [31:0]   mem_pc_q    [DEPTH];
  logic [31:0]   mem_instr_q [DEPTH];

  logic          not_empty;
  logic          deq;
  logic          enq;
  logic [31:0]   fetch_pc_plus4;

  assign not_empty      = (count_q != '0);
  assign deq            = id_ready & not_empty & ~flush;
  // A full queue may still fetch when the head leaves in the same cycle.
  assign enq            = ~flush & ((count_q < FULL) | deq);
  assign fetch_pc_plus4 = fetch_pc_q + 32'd4;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (flush) begin
      fetch_pc_d = flush_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (enq) begin
        fetch_pc_d = fetch_pc_plus4;
        wr_ptr_d   = wr_ptr_q + 1'b1;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (enq && !deq) begin
        count_d = count_q + 1'b1;
      end else if (deq && !enq) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Reset must also block writes so a reset cycle never deposits an entry.
  always_ff @(posedge clk) begin
    if (rst_n && enq) begin
      mem_pc_q[wr_ptr_q]    <= fetch_pc_plus4;
      mem_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign count     = count_q;
  assign id_valid  = not_empty & ~flush;
  assign id_pc     = id_valid ? mem_pc_q[rd_ptr_q]    : 32'd0;
  assign id_instr  = id_valid ? mem_instr_q[rd_ptr_q] : NOP_INSTR;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: memory word at byte address a is 32'h1000_0000 + a/4.
module tb_instr_fetch_queue;

  localparam logic [31:0] NOP = 32'h0041_0020;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [2:0]  count;

  int tests_run;
  int tests_failed;

  instr_fetch_queue #(
    .DEPTH(4), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .id_ready(id_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .count(count)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = BASE + {2'b00, imem_addr[31:2]};

  // Inputs change 1 time unit after the rising edge; checks run 2 units after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst_n    = 1'b0;
    flush    = 1'b0;
    flush_pc = 32'd0;
    id_ready = ready;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    tests_run++;
    if ({id_valid, id_pc, id_instr, count, imem_addr} !== {1'b0, 32'd0, NOP, 3'd0, 32'd0}) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%0b pc=%h instr=%h cnt=%0d addr=%h, want v=0 pc=0 instr=%h cnt=0 addr=0",
               id_valid, id_pc, id_instr, count, imem_addr, NOP);
    end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      tests_run++;
      if ({id_valid, id_pc, id_instr, count} !== {1'b1, 32'(4 * (i + 1)), BASE + 32'(i), 3'd1}) begin
        tests_failed++;
        $display("FAIL stream[%0d]: got v=%0b pc=%h instr=%h cnt=%0d, want v=1 pc=%h instr=%h cnt=1",
                 i, id_valid, id_pc, id_instr, count, 32'(4 * (i + 1)), BASE + 32'(i));
      end
    end
  endtask

  task automatic test_stall_fill_drain();
    int c;
    do_reset(1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      #1;
      c = (k > 4) ? 4 : k;
      tests_run++;
      if ({count, imem_addr, id_valid, id_instr, id_pc} !== {3'(c), 32'(4 * c), 1'b1, BASE, 32'd4}) begin
        tests_failed++;
        $display("FAIL stall_fill[%0d]: got cnt=%0d addr=%h v=%0b instr=%h pc=%h, want cnt=%0d addr=%h v=1 instr=%h pc=4",
                 k, count, imem_addr, id_valid, id_instr, id_pc, c, 32'(4 * c), BASE);
      end
    end
    id_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if ({id_valid, id_instr, id_pc, count} !== {1'b1, BASE + 32'(i), 32'(4 * (i + 1)), 3'd4}) begin
        tests_failed++;
        $display("FAIL drain[%0d]: got v=%0b instr=%h pc=%h cnt=%0d, want v=1 instr=%h pc=%h cnt=4",
                 i, id_valid, id_instr, id_pc, count, BASE + 32'(i), 32'(4 * (i + 1)));
      end
      tick();
      #1;
    end
  endtask

  task automatic test_full_single_go();
    do_reset(1'b0);
    repeat (4) tick();
    id_ready = 1'b1;
    #1;
    tests_run++;
    if ({count, imem_addr} !== {3'd4, 32'h10}) begin
      tests_failed++;
      $display("FAIL full_before: got cnt=%0d addr=%h, want cnt=4 addr=10", count, imem_addr);
    end
    tick();
    id_ready = 1'b0;
    #1;
    tests_run++;
    if ({count, imem_addr, id_instr, id_pc} !== {3'd4, 32'h14, BASE + 32'd1, 32'd8}) begin
      tests_failed++;
      $display("FAIL full_after: got cnt=%0d addr=%h instr=%h pc=%h, want cnt=4 addr=14 instr=%h pc=8",
               count, imem_addr, id_instr, id_pc, BASE + 32'd1);
    end
  endtask

  task automatic test_flush();
    do_reset(1'b0);
    repeat (3) tick();
    flush    = 1'b1;
    flush_pc = 32'h40;
    #1;
    tests_run++;
    if ({count, id_valid, id_instr, id_pc} !== {3'd3, 1'b0, NOP, 32'd0}) begin
      tests_failed++;
      $display("FAIL flush_cycle: got cnt=%0d v=%0b instr=%h pc=%h, want cnt=3 v=0 instr=%h pc=0",
               count, id_valid, id_instr, id_pc, NOP);
    end
    tick();
    flush    = 1'b0;
    id_ready = 1'b1;
    #1;
    tests_run++;
    if ({count, imem_addr, id_valid, id_instr} !== {3'd0, 32'h40, 1'b0, NOP}) begin
      tests_failed++;
      $display("FAIL flush_next: got cnt=%0d addr=%h v=%0b instr=%h, want cnt=0 addr=40 v=0 instr=%h",
               count, imem_addr, id_valid, id_instr, NOP);
    end
    tick();
    #1;
    tests_run++;
    if ({id_valid, id_instr, id_pc} !== {1'b1, BASE + 32'h10, 32'h44}) begin
      tests_failed++;
      $display("FAIL flush_target: got v=%0b instr=%h pc=%h, want v=1 instr=%h pc=44",
               id_valid, id_instr, id_pc, BASE + 32'h10);
    end
  endtask

  task automatic test_reset_beats_flush();
    do_reset(1'b0);
    repeat (3) tick();
    rst_n    = 1'b0;
    flush    = 1'b1;
    flush_pc = 32'h80;
    tick();
    rst_n = 1'b1;
    #1;
    tests_run++;
    if ({imem_addr, count, id_valid} !== {32'd0, 3'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_vs_flush: got addr=%h cnt=%0d v=%0b, want addr=0 cnt=0 v=0",
               imem_addr, count, id_valid);
    end
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      tests_run++;
      if ({imem_addr, count, id_valid, id_instr, id_pc} !== {32'h80, 3'd0, 1'b0, NOP, 32'd0}) begin
        tests_failed++;
        $display("FAIL held_flush[%0d]: got addr=%h cnt=%0d v=%0b instr=%h pc=%h, want addr=80 cnt=0 v=0 instr=%h pc=0",
                 i, imem_addr, count, id_valid, id_instr, id_pc, NOP);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [23:0] pattern;
    int          m_cnt;
    int          f_idx;
    logic        m_deq;
    logic        m_enq;
    pattern = 24'b1101_0000_1011_0011_1000_0110;
    do_reset(1'b0);
    m_cnt = 0;
    f_idx = 0;
    for (int i = 0; i < 24; i++) begin
      id_ready = pattern[i];
      #1;
      tests_run++;
      if (m_cnt != 0) begin
        if ({count, id_valid, id_instr, id_pc} !== {3'(m_cnt), 1'b1, exp_q[0], 32'(4 * (exp_q[0] - BASE + 1))}) begin
          tests_failed++;
          $display("FAIL order[%0d]: got cnt=%0d v=%0b instr=%h pc=%h, want cnt=%0d v=1 instr=%h",
                   i, count, id_valid, id_instr, id_pc, m_cnt, exp_q[0]);
        end
      end else if ({count, id_valid, id_instr} !== {3'd0, 1'b0, NOP}) begin
        tests_failed++;
        $display("FAIL order_empty[%0d]: got cnt=%0d v=%0b instr=%h, want cnt=0 v=0 instr=%h",
                 i, count, id_valid, id_instr, NOP);
      end
      m_deq = pattern[i] && (m_cnt != 0);
      m_enq = (m_cnt < 4) || m_deq;
      if (m_deq) begin
        void'(exp_q.pop_front());
        m_cnt--;
      end
      if (m_enq) begin
        exp_q.push_back(BASE + 32'(f_idx));
        f_idx++;
        m_cnt++;
      end
      tick();
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    flush        = 1'b0;
    flush_pc     = 32'd0;
    id_ready     = 1'b0;
    test_reset();
    test_stream();
    test_stall_fill_drain();
    test_full_single_go();
    test_flush();
    test_reset_beats_flush();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
